rtype_issue_ctrl: RTL and testbench
===================================

# rtype_issue_ctrl

Multi-cycle issue controller that feeds the register-file/ALU datapath. It accepts 32-bit LEGv8 R-type instruction words over a valid/ready handshake and splits them into fields. It drives the read/write register selects, ALUOp, Opcode and a single-cycle RegWrite strobe into the datapath. It also samples the datapath's Zero and ALU_Result, flags unsupported opcodes, and keeps retire and illegal counters.

## Interface
- no parameters; widths are fixed by the 64-bit datapath.
- clock  in  1  sole clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- in_valid  in  1  instruction word on in_instr is valid.
- in_instr  in  32  LEGv8 R-format: [31:21] opcode, [20:16] Rm, [15:10] shamt (ignored), [9:5] Rn, [4:0] Rd.
- in_ready  out  1  controller can accept; high only in IDLE.
- Read1  out  5  register select, driven with Rn.
- Read2  out  5  register select, driven with Rm.
- WriteReg  out  5  register select, driven with Rd.
- ALUOp  out  2  constant 2'b10 (R-type) while busy; 2'b00 in IDLE.
- Opcode  out  11  instr[31:21] of the instruction in flight.
- RegWrite  out  1  one-cycle write strobe.
- Zero  in  1  datapath zero flag.
- ALU_Result  in  64  datapath result.
- result_q  out  64  last sampled ALU_Result.
- zero_q  out  1  last sampled Zero.
- illegal  out  1  one-cycle pulse when an unsupported opcode is rejected.
- retired_count  out  16  count of instructions completed through WB; wraps at 16'hFFFF -> 0.
- illegal_count  out  8  count of rejected instructions; saturates at 8'hFF.

## Operation
- States: IDLE, DECODE, EXEC, WB. All outputs are registered.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready, latch in_instr into instr_q and go to DECODE.
  - With no handshake, stay in IDLE.
- DECODE:
  - Drive Read1/Read2/WriteReg/Opcode from instr_q and ALUOp=2'b10.
  - Legal opcodes are ADD 10001011000, SUB 11001011000, AND 10001010000 and ORR 10101010000.
  - Legal opcode: go to EXEC.
  - Any other opcode: pulse illegal for one cycle, increment illegal_count (saturating), return to IDLE. No RegWrite is issued.
- EXEC: selects held stable, so the ALU settles. At the end of the cycle, capture ALU_Result into result_q and Zero into zero_q. Go to WB.
- WB:
  - Selects are still held.
  - RegWrite=1 for exactly this cycle, except when Rd==5'd31 (XZR): then RegWrite stays 0.
  - The instruction still retires in both cases; increment retired_count.
  - Go to IDLE.
- Register selects are held from DECODE through WB. They change only when a new instruction is latched.
- in_instr is sampled only at the handshake; changes to in_instr while busy are ignored.
- in_valid asserted while busy: no acceptance. The producer must hold the word until it sees in_ready.

## Timing
- Reset values: state IDLE, in_ready=1, Read1/Read2/WriteReg=0, Opcode=0, ALUOp=2'b00, RegWrite=0, illegal=0, result_q=0, zero_q=0, both counters 0.
- Legal instruction latency: handshake at edge N, then DECODE in N+1, EXEC in N+2, RegWrite high in N+3. The register-file write lands at edge N+4, and in_ready is high again in cycle N+4.
- Legal throughput: 1 instruction per 4 cycles.
- Illegal instruction: illegal is high in cycle N+1, in_ready is high in N+2 (2-cycle occupancy).
- result_q/zero_q update at the EXEC->WB edge and hold until the next legal EXEC.
- Reset asserted mid-instruction (any state): immediate return to IDLE with all outputs at reset values. A RegWrite in progress is dropped and counters clear.
- Back-to-back: a handshake in the first IDLE cycle after WB is accepted. There are no idle bubbles beyond IDLE itself.
- retired_count increments on the WB->IDLE edge; illegal_count increments on the DECODE->IDLE edge.

## Test plan
- ADD X3,X1,X2 (instr 32'h8B020023) with X1=5, X2=7 preloaded:
  - RegWrite high exactly in cycle N+3 with WriteReg=3.
  - result_q=12, zero_q=0.
  - retired_count=1.
- SUB X4,X1,X1 (32'hCB010024):
  - result_q=0, zero_q=1.
  - RegWrite pulse with WriteReg=4.
- Opcode 11'h7FF with Rd=2:
  - illegal pulse in cycle N+1, no RegWrite, illegal_count=1, in_ready high at N+2.
  - Repeat 300 times: illegal_count sticks at 8'hFF.
- ORR with Rd=31:
  - RegWrite stays 0 through WB; retired_count still increments; result_q updated.
- Four ADDs offered with in_valid held high continuously:
  - exactly one accepted every 4 cycles; in_ready low in DECODE/EXEC/WB.
  - Opcode/selects stable over each 3-cycle window.
- Reset pulsed during EXEC of an AND:
  - no RegWrite ever asserted; all outputs return to reset values.
  - next instruction is accepted normally.

Source files
------------

// File: rtl/rtype_issue_ctrl_if.sv
// Instruction handshake plus datapath control/status bundle between the issue
// controller (slave) and the producer/datapath side (master).
interface rtype_issue_ctrl_if;
  logic        in_valid;
  logic [31:0] in_instr;
  logic        in_ready;
  logic [4:0]  Read1;
  logic [4:0]  Read2;
  logic [4:0]  WriteReg;
  logic [1:0]  ALUOp;
  logic [10:0] Opcode;
  logic        RegWrite;
  logic        Zero;
  logic [63:0] ALU_Result;
  logic [63:0] result_q;
  logic        zero_q;
  logic        illegal;
  logic [15:0] retired_count;
  logic [7:0]  illegal_count;

  modport master (
    output in_valid, in_instr, Zero, ALU_Result,
    input  in_ready, Read1, Read2, WriteReg, ALUOp, Opcode, RegWrite,
           result_q, zero_q, illegal, retired_count, illegal_count
  );

  modport slave (
    input  in_valid, in_instr, Zero, ALU_Result,
    output in_ready, Read1, Read2, WriteReg, ALUOp, Opcode, RegWrite,
           result_q, zero_q, illegal, retired_count, illegal_count
  );
endinterface

// File: rtl/rtype_issue_ctrl.sv
// Four-state (IDLE/DECODE/EXEC/WB) issue controller for LEGv8 R-type words:
// latches one instruction, steers the register file/ALU and retires it.
module rtype_issue_ctrl (
  input logic               clock,
  input logic               reset,
  rtype_issue_ctrl_if.slave bus
);
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] DECODE = 2'd1;
  localparam logic [1:0] EXEC   = 2'd2;
  localparam logic [1:0] WB     = 2'd3;

  localparam logic [10:0] OP_ADD = 11'b10001011000;
  localparam logic [10:0] OP_SUB = 11'b11001011000;
  localparam logic [10:0] OP_AND = 11'b10001010000;
  localparam logic [10:0] OP_ORR = 11'b10101010000;
  localparam logic [4:0]  XZR    = 5'd31;

  logic [1:0]  state;
  // Latched {opcode, Rm, Rn, Rd}; shamt is never consulted so it is not kept.
  logic [25:0] instr_q;
  logic        legal_q;
  logic        ready_q;
  logic        regwrite_q;
  logic        illegal_q;
  logic [1:0]  aluop_q;
  logic [63:0] result_r;
  logic        zero_r;
  logic [15:0] retired_r;
  logic [7:0]  illegal_cnt_r;
  logic        accept;

  function automatic logic is_legal(input logic [10:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_ORR);
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // ready_q is high exactly in IDLE, so it doubles as the acceptance gate.
  assign accept = bus.in_valid && ready_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      instr_q       <= '0;
      legal_q       <= 1'b0;
      ready_q       <= 1'b1;
      regwrite_q    <= 1'b0;
      illegal_q     <= 1'b0;
      aluop_q       <= 2'b00;
      result_r      <= '0;
      zero_r        <= 1'b0;
      retired_r     <= '0;
      illegal_cnt_r <= '0;
    end else begin
      regwrite_q <= 1'b0;
      illegal_q  <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            instr_q   <= {bus.in_instr[31:16], bus.in_instr[9:0]};
            legal_q   <= is_legal(bus.in_instr[31:21]);
            // The reject pulse must be visible during DECODE itself.
            illegal_q <= !is_legal(bus.in_instr[31:21]);
            ready_q   <= 1'b0;
            aluop_q   <= 2'b10;
            state     <= DECODE;
          end
        end
        DECODE: begin
          if (legal_q) begin
            state <= EXEC;
          end else begin
            illegal_cnt_r <= sat_inc8(illegal_cnt_r);
            ready_q       <= 1'b1;
            aluop_q       <= 2'b00;
            state         <= IDLE;
          end
        end
        EXEC: begin
          result_r   <= bus.ALU_Result;
          zero_r     <= bus.Zero;
          regwrite_q <= (instr_q[4:0] != XZR);
          state      <= WB;
        end
        default: begin
          retired_r <= retired_r + 16'd1;
          ready_q   <= 1'b1;
          aluop_q   <= 2'b00;
          state     <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready      = ready_q;
  assign bus.Opcode        = instr_q[25:15];
  assign bus.Read2         = instr_q[14:10];
  assign bus.Read1         = instr_q[9:5];
  assign bus.WriteReg      = instr_q[4:0];
  assign bus.ALUOp         = aluop_q;
  assign bus.RegWrite      = regwrite_q;
  assign bus.illegal       = illegal_q;
  assign bus.result_q      = result_r;
  assign bus.zero_q        = zero_r;
  assign bus.retired_count = retired_r;
  assign bus.illegal_count = illegal_cnt_r;
endmodule

// File: tb/tb_rtype_issue_ctrl.sv
// Bench for rtype_issue_ctrl: a register-file/ALU stand-in plus a
// transaction-level reference model driven by directed and random words.
module tb_rtype_issue_ctrl;
  localparam logic [10:0] OP_ADD = 11'b10001011000;
  localparam logic [10:0] OP_SUB = 11'b11001011000;
  localparam logic [10:0] OP_AND = 11'b10001010000;
  localparam logic [10:0] OP_ORR = 11'b10101010000;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  rtype_issue_ctrl_if bus ();
  rtype_issue_ctrl dut (.clock(clock), .reset(reset), .bus(bus));

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Datapath stand-in: register file (X31 reads zero) and a four-op ALU.
  logic [63:0] dp_regs [32];
  logic        load_en;
  logic [4:0]  load_idx;
  logic [63:0] load_val;
  logic [63:0] alu_a, alu_b, alu_res;

  always_comb begin
    alu_res = '0;
    alu_a   = dp_regs[bus.Read1];
    alu_b   = dp_regs[bus.Read2];
    case (bus.Opcode)
      OP_ADD:  alu_res = alu_a + alu_b;
      OP_SUB:  alu_res = alu_a - alu_b;
      OP_AND:  alu_res = alu_a & alu_b;
      OP_ORR:  alu_res = alu_a | alu_b;
      default: alu_res = '0;
    endcase
  end
  assign bus.ALU_Result = alu_res;
  assign bus.Zero       = (alu_res == 64'd0);

  always @(posedge clock) begin
    if (load_en) dp_regs[load_idx] <= load_val;
    else if (bus.RegWrite && bus.WriteReg != 5'd31) dp_regs[bus.WriteReg] <= alu_res;
  end

  // Reference model state.
  logic [63:0] mdl_regs [32];
  logic [63:0] mdl_result;
  logic        mdl_zero;
  int          mdl_retired;
  int          mdl_illegal;
  bit          prev_hold;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ready"}, bus.in_ready, 1);
    chk({tag, "_read1"}, bus.Read1, 0);
    chk({tag, "_read2"}, bus.Read2, 0);
    chk({tag, "_wreg"}, bus.WriteReg, 0);
    chk({tag, "_opcode"}, bus.Opcode, 0);
    chk({tag, "_aluop"}, bus.ALUOp, 0);
    chk({tag, "_regwrite"}, bus.RegWrite, 0);
    chk({tag, "_illegal"}, bus.illegal, 0);
    chk({tag, "_result"}, bus.result_q, 0);
    chk({tag, "_zero"}, bus.zero_q, 0);
    chk({tag, "_retired"}, bus.retired_count, 0);
    chk({tag, "_illcnt"}, bus.illegal_count, 0);
  endtask

  function automatic logic [63:0] ref_alu(input logic [10:0] op, input logic [63:0] a,
                                          input logic [63:0] b);
    if (op == OP_ADD) return a + b;
    if (op == OP_SUB) return a - b;
    if (op == OP_AND) return a & b;
    return a | b;
  endfunction

  // Offers one word (called at a negedge) and follows it cycle by cycle to retirement.
  // With hold set, in_valid stays high with junk on in_instr while busy.
  task automatic send(input logic [31:0] w, input bit hold);
    logic [10:0] op;
    logic [4:0]  rm, rn, rd;
    bit          legal;
    logic [63:0] res;
    int          waited;
    op = w[31:21]; rm = w[20:16]; rn = w[9:5]; rd = w[4:0];
    legal = (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_ORR);
    bus.in_valid = 1'b1;
    bus.in_instr = w;
    waited = 0;
    while (bus.in_ready !== 1'b1 && waited < 16) begin
      @(negedge clock);
      waited++;
    end
    if (bus.in_ready !== 1'b1) begin
      chk("accept_timeout", bus.in_ready, 1);
      bus.in_valid = 1'b0;
      return;
    end
    if (prev_hold) chk("b2b_bubble", waited, 0);

    @(negedge clock);  // DECODE
    bus.in_valid = hold;
    bus.in_instr = $urandom;
    chk("dec_ready", bus.in_ready, 0);
    chk("dec_read1", bus.Read1, rn);
    chk("dec_read2", bus.Read2, rm);
    chk("dec_wreg", bus.WriteReg, rd);
    chk("dec_opcode", bus.Opcode, op);
    chk("dec_aluop", bus.ALUOp, 2'b10);
    chk("dec_regwrite", bus.RegWrite, 0);
    chk("dec_illegal", bus.illegal, !legal);

    if (!legal) begin
      if (mdl_illegal < 255) mdl_illegal++;
      @(negedge clock);  // back in IDLE
      chk("ill_ready", bus.in_ready, 1);
      chk("ill_pulse", bus.illegal, 0);
      chk("ill_regwrite", bus.RegWrite, 0);
      chk("ill_aluop", bus.ALUOp, 0);
      chk("ill_count", bus.illegal_count, mdl_illegal);
      chk("ill_result_held", bus.result_q, mdl_result);
      prev_hold = hold;
      return;
    end

    res = ref_alu(op, mdl_regs[rn], mdl_regs[rm]);
    @(negedge clock);  // EXEC
    chk("exe_ready", bus.in_ready, 0);
    chk("exe_regwrite", bus.RegWrite, 0);
    chk("exe_illegal", bus.illegal, 0);
    chk("exe_wreg", bus.WriteReg, rd);
    chk("exe_opcode", bus.Opcode, op);
    chk("exe_result_held", bus.result_q, mdl_result);
    mdl_result = res;
    mdl_zero   = (res == 64'd0);

    @(negedge clock);  // WB
    chk("wb_ready", bus.in_ready, 0);
    chk("wb_regwrite", bus.RegWrite, rd != 5'd31);
    chk("wb_wreg", bus.WriteReg, rd);
    chk("wb_read1", bus.Read1, rn);
    chk("wb_aluop", bus.ALUOp, 2'b10);
    chk("wb_result", bus.result_q, mdl_result);
    chk("wb_zero", bus.zero_q, mdl_zero);
    chk("wb_retired_old", bus.retired_count, mdl_retired);
    mdl_retired = (mdl_retired + 1) % 65536;
    if (rd != 5'd31) mdl_regs[rd] = res;

    @(negedge clock);  // IDLE again
    chk("ret_ready", bus.in_ready, 1);
    chk("ret_regwrite", bus.RegWrite, 0);
    chk("ret_aluop", bus.ALUOp, 0);
    chk("ret_retired", bus.retired_count, mdl_retired);
    chk("ret_sel_held", bus.WriteReg, rd);
    chk("ret_regfile", dp_regs[rd], mdl_regs[rd]);
    prev_hold = hold;
  endtask

  task automatic reset_mid_and();
    int waited;
    bus.in_valid = 1'b1;
    bus.in_instr = {OP_AND, 5'd2, 6'd0, 5'd1, 5'd5};
    waited = 0;
    while (bus.in_ready !== 1'b1 && waited < 16) begin
      @(negedge clock);
      waited++;
    end
    chk("rst_accept", bus.in_ready, 1);
    @(negedge clock);  // DECODE
    bus.in_valid = 1'b0;
    @(negedge clock);  // EXEC
    #2 reset = 1'b1;
    #1 chk_reset_vals("rst_async");
    mdl_result = '0; mdl_zero = 1'b0; mdl_retired = 0; mdl_illegal = 0;
    @(negedge clock);
    chk("rst_hold_regwrite", bus.RegWrite, 0);
    reset = 1'b0;
    @(negedge clock);
    chk_reset_vals("rst_after");
    @(negedge clock);
    chk("rst_no_regwrite", bus.RegWrite, 0);
    chk("rst_regfile", dp_regs[5], mdl_regs[5]);
    prev_hold = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [10:0] op;
    logic [31:0] w;
    bit          hold;
    reset = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_instr = '0;
    load_en = 1'b0; load_idx = '0; load_val = '0;
    prev_hold = 1'b0;
    mdl_result = '0; mdl_zero = 1'b0; mdl_retired = 0; mdl_illegal = 0;
    for (int i = 0; i < 32; i++) mdl_regs[i] = (i == 31) ? 64'd0 : {$urandom, $urandom};
    mdl_regs[1] = 64'd5;
    mdl_regs[2] = 64'd7;
    for (int i = 0; i < 32; i++) begin
      @(negedge clock);
      load_en = 1'b1; load_idx = 5'(i); load_val = mdl_regs[i];
    end
    @(negedge clock);
    load_en = 1'b0;
    chk_reset_vals("por");
    reset = 1'b0;
    @(negedge clock);
    chk_reset_vals("idle");

    send(32'h8B020023, 1'b0);  // ADD X3,X1,X2
    chk("add_result", bus.result_q, 64'd12);
    chk("add_zero", bus.zero_q, 0);
    chk("add_retired", bus.retired_count, 1);
    chk("add_x3", dp_regs[3], 64'd12);

    send(32'hCB010024, 1'b0);  // SUB X4,X1,X1
    chk("sub_result", bus.result_q, 64'd0);
    chk("sub_zero", bus.zero_q, 1);
    chk("sub_retired", bus.retired_count, 2);

    for (int i = 0; i < 300; i++) send({11'h7FF, 5'd0, 6'd0, 5'd0, 5'd2}, 1'b0);
    chk("ill_saturated", bus.illegal_count, 8'hFF);

    send({OP_ORR, 5'd2, 6'd0, 5'd1, 5'd31}, 1'b0);
    chk("orr_xzr_result", bus.result_q, 64'd7);
    chk("orr_xzr_retired", bus.retired_count, 3);

    for (int k = 0; k < 4; k++)
      send({OP_ADD, 5'($urandom), 6'($urandom), 5'($urandom), 5'($urandom)}, k != 3);

    reset_mid_and();
    send({OP_ADD, 5'd1, 6'd0, 5'd2, 5'd6}, 1'b0);
    chk("post_rst_retired", bus.retired_count, 1);

    for (int i = 0; i < 150; i++) begin
      case ($urandom_range(0, 4))
        0: op = OP_ADD;
        1: op = OP_SUB;
        2: op = OP_AND;
        3: op = OP_ORR;
        default: op = 11'($urandom);
      endcase
      w = {op, 5'($urandom), 6'($urandom), 5'($urandom), 5'($urandom)};
      hold = (i != 149) && ($urandom_range(0, 1) == 1);
      send(w, hold);
    end
    bus.in_valid = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
